// File: rtl/noc_pkg.sv
// ============================================================================
// Package     : noc_pkg
// Description : Shared flit field positions, port codes and arbiter FSM
//               state type for the 4-interface NoC router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    // Destination codes, one per router output port
    localparam logic [1:0] PORT_E = 2'b00;
    localparam logic [1:0] PORT_W = 2'b01;
    localparam logic [1:0] PORT_L = 2'b10;
    localparam logic [1:0] PORT_3 = 2'b11;

    // Flit field positions
    localparam int VALID_BIT = 0;
    localparam int DEST_LSB  = 1;
    localparam int SRC_LSB   = 3;

    // Output-port arbiter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/noc_rr_arbiter4.sv
// ============================================================================
// Module      : noc_rr_arbiter4
// Description : Combinational 4-way round-robin picker. The search starts at
//               rr_ptr and wraps modulo 4; the first requester wins. The
//               pointer itself is owned by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] w_idx;

    // Scan the four candidates starting at the pointer, keep the first hit
    always_comb begin
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        any     = 1'b0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = rr_ptr + 2'(k);
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                gnt_idx      = w_idx;
                gnt[w_idx]   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_port_arbiter.sv
// ============================================================================
// Module      : noc_port_arbiter
// Description : Output-port scheduler. Picks, round-robin, one input FIFO
//               whose head flit targets PORT_ID, pops it and forwards a
//               registered flit and write strobe downstream, honouring
//               full / almost-full backpressure.
//               Optional macro NOC_ARB_STATS_EN adds saturating per-input
//               grant counters and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int         WIDTH   = 12,
    parameter logic [1:0] PORT_ID = PORT_E
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         fifo_empty,
    input  logic [4*WIDTH-1:0] head_data,
    output logic [3:0]         pop,
    input  logic               dest_full,
    input  logic               dest_almost_full,
    output logic [WIDTH-1:0]   data_out,
    output logic               write_out,
    output logic [1:0]         grant_idx,
    output logic               stalled
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [63:0]        grant_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    logic [WIDTH-1:0] w_head [4];
    logic [3:0]       w_req;
    logic [3:0]       w_gnt;
    logic [1:0]       w_gnt_idx;
    logic             w_any;
    logic             w_can_send;
    logic             w_grant;

    logic [1:0]       r_rr_ptr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_write_out;
    logic [1:0]       r_grant_idx;
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    // Slice head flits and decode which inputs are asking for this port
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign w_head[gi] = head_data[gi*WIDTH +: WIDTH];
            assign w_req[gi]  = !fifo_empty[gi] && w_head[gi][VALID_BIT] &&
                                (w_head[gi][DEST_LSB +: 2] == PORT_ID);
        end
    endgenerate

    // A write already in flight consumes the last downstream slot
    assign w_can_send = !dest_full && !(r_write_out && dest_almost_full);
    assign w_grant    = reset && w_can_send && w_any;

    noc_rr_arbiter4 u_rr (
        .req     (w_req),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign pop       = w_grant ? w_gnt : 4'b0000;
    assign data_out  = r_data_out;
    assign write_out = r_write_out;
    assign grant_idx = r_grant_idx;
    assign stalled   = (r_state == STALL);

    // Datapath register: capture the granted flit, advance the pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= 2'd0;
            r_data_out  <= '0;
            r_write_out <= 1'b0;
            r_grant_idx <= 2'd0;
        end else if (w_grant) begin
            r_rr_ptr    <= w_gnt_idx + 2'd1;
            r_data_out  <= w_head[w_gnt_idx];
            r_write_out <= 1'b1;
            r_grant_idx <= w_gnt_idx;
        end else begin
            r_write_out <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: every state moves the same way on req / can_send
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, SEND, STALL: begin
                if (!w_any) begin
                    w_state_nxt = IDLE;
                end else if (w_can_send) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = STALL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef NOC_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    generate
        for (genvar gc = 0; gc < 4; gc++) begin : g_cnt
            logic [15:0] r_cnt;
            // Per-input saturating grant counter
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= 16'd0;
                end else if (pop[gc] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[gc*16 +: 16] = r_cnt;
        end
    endgenerate

    // Saturating count of cycles spent in STALL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_port_arbiter.sv
// ============================================================================
// Module      : tb_noc_port_arbiter
// Description : Self-checking bench for noc_port_arbiter (PORT_ID = E).
//               Vector table plus hand-written reset, fairness and
//               mid-transfer reset sequences; forwarded flits are checked
//               against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_port_arbiter;

    localparam int W = 12;

    logic          clk;
    logic          reset;
    logic [3:0]    fifo_empty;
    logic [4*W-1:0] head_data;
    logic [3:0]    pop;
    logic          dest_full;
    logic          dest_almost_full;
    logic [W-1:0]  data_out;
    logic          write_out;
    logic [1:0]    grant_idx;
    logic          stalled;
`ifdef NOC_ARB_STATS_EN
    logic [63:0]   grant_cnt;
    logic [15:0]   stall_cnt;
`endif

    noc_port_arbiter #(.WIDTH(W), .PORT_ID(2'b00)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .head_data        (head_data),
        .pop              (pop),
        .dest_full        (dest_full),
        .dest_almost_full (dest_almost_full),
        .data_out         (data_out),
        .write_out        (write_out),
        .grant_idx        (grant_idx),
        .stalled          (stalled)
`ifdef NOC_ARB_STATS_EN
        ,
        .grant_cnt        (grant_cnt),
        .stall_cnt        (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]     fe;
        logic [4*W-1:0] hd;
        logic           df;
        logic           af;
        logic [3:0]     exp_pop;
        logic           exp_stall;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   idx;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] last_pop;
    vec_t       tbl[14];
    int         gcount[4];

    function automatic logic [W-1:0] mk(input logic [6:0] pay, input logic [1:0] src,
                                        input logic [1:0] dst, input logic v);
        return {pay, src, dst, v};
    endfunction

    function automatic logic [4*W-1:0] all_heads(input logic [6:0] base);
        return {mk(base + 7'd3, 2'd3, 2'b00, 1'b1), mk(base + 7'd2, 2'd2, 2'b00, 1'b1),
                mk(base + 7'd1, 2'd1, 2'b00, 1'b1), mk(base, 2'd0, 2'b00, 1'b1)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, check pop, clock, check the write and stall
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        fifo_empty       = v.fe;
        head_data        = v.hd;
        dest_full        = v.df;
        dest_almost_full = v.af;
        #4;
        last_pop = pop;
        chk({nm, ".pop"}, 64'(pop), 64'(v.exp_pop));
        for (int i = 0; i < 4; i++) begin
            if (v.exp_pop[i]) begin
                e.data = v.hd[i*W +: W];
                e.idx  = 2'(i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk({nm, ".write_out"}, 64'(write_out), 64'(v.exp_pop != 4'b0000));
        chk({nm, ".stalled"}, 64'(stalled), 64'(v.exp_stall));
        if (write_out) begin
            if (sb.size() == 0) begin
                chk({nm, ".unexpected_write"}, 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk({nm, ".data_out"}, 64'(data_out), 64'(e.data));
                chk({nm, ".grant_idx"}, 64'(grant_idx), 64'(e.idx));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".pop"}, 64'(pop), 64'(0));
        chk({nm, ".write_out"}, 64'(write_out), 64'(0));
        chk({nm, ".data_out"}, 64'(data_out), 64'(0));
        chk({nm, ".grant_idx"}, 64'(grant_idx), 64'(0));
        chk({nm, ".stalled"}, 64'(stalled), 64'(0));
`ifdef NOC_ARB_STATS_EN
        chk({nm, ".grant_cnt"}, grant_cnt, 64'(0));
        chk({nm, ".stall_cnt"}, 64'(stall_cnt), 64'(0));
`endif
    endtask

    initial begin
        logic [4*W-1:0] hall;
        logic [4*W-1:0] hfilt;
        logic [4*W-1:0] hsolo;
        vec_t v;

        hall  = all_heads(7'h10);
        hfilt = {mk(7'h33, 2'd3, 2'b00, 1'b0), mk(7'h22, 2'd2, 2'b00, 1'b1),
                 mk(7'h11, 2'd1, 2'b01, 1'b1), mk(7'h00, 2'd0, 2'b00, 1'b1)};
        hsolo = {mk(7'h43, 2'd3, 2'b00, 1'b1), 12'h0A1,
                 mk(7'h41, 2'd1, 2'b00, 1'b1), mk(7'h40, 2'd0, 2'b00, 1'b1)};

        //         fe       hd     df    af    exp_pop  exp_stall
        tbl[0]  = '{4'b0000, hall,  1'b0, 1'b0, 4'b0001, 1'b0};
        tbl[1]  = '{4'b0000, hall,  1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[2]  = '{4'b0000, hall,  1'b0, 1'b0, 4'b0100, 1'b0};
        tbl[3]  = '{4'b0000, hall,  1'b0, 1'b0, 4'b1000, 1'b0};
        tbl[4]  = '{4'b1011, hsolo, 1'b0, 1'b0, 4'b0100, 1'b0};
        tbl[5]  = '{4'b0101, hfilt, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, hall,  1'b1, 1'b0, 4'b0000, 1'b1};
        tbl[7]  = '{4'b0000, hall,  1'b0, 1'b0, 4'b1000, 1'b0};
        tbl[8]  = '{4'b0101, hall,  1'b0, 1'b0, 4'b0010, 1'b0};
        tbl[9]  = '{4'b0101, hall,  1'b0, 1'b0, 4'b1000, 1'b0};
        tbl[10] = '{4'b0101, hall,  1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[11] = '{4'b0101, hall,  1'b0, 1'b1, 4'b0010, 1'b0};
        tbl[12] = '{4'b0101, hall,  1'b0, 1'b1, 4'b0000, 1'b1};
        tbl[13] = '{4'b0000, hall,  1'b0, 1'b0, 4'b0100, 1'b0};

        // Reset held with every FIFO offering a matching flit
        reset            = 1'b0;
        fifo_empty       = 4'b0000;
        head_data        = hall;
        dest_full        = 1'b0;
        dest_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        check_reset_state("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // Vector table; rr_ptr ends at 3
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Fairness: 100 continuous grants, rotating from input 3
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        for (int n = 0; n < 100; n++) begin
            v = '{4'b0000, all_heads(7'(n)), 1'b0, 1'b0, 4'(1 << ((3 + n) % 4)), 1'b0};
            apply(v, $sformatf("fair%0d", n));
            for (int i = 0; i < 4; i++) if (last_pop[i]) gcount[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair_count%0d", i), 64'(gcount[i]), 64'(25));
        end

        // Mid-transfer reset: rr_ptr is 3, take two grants so it becomes 1
        apply('{4'b0000, hall, 1'b0, 1'b0, 4'b1000, 1'b0}, "pre_rst0");
        apply('{4'b0000, hall, 1'b0, 1'b0, 4'b0001, 1'b0}, "pre_rst1");
        chk("pre_rst.write_out", 64'(write_out), 64'(1));
        reset = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        // Pointer back at 0: input 0 wins again rather than input 1
        apply('{4'b0000, hall, 1'b0, 1'b0, 4'b0001, 1'b0}, "post_rst");

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
